lsu: RTL and testbench
======================

# lsu

Load/store unit for the MEM stage. It sits directly downstream of the EX/MEM pipeline register and consumes that register's outputs: uop, address, store data, rd/CSR write info, exception vector, pc and instruction. It runs a registered req/ack transaction on the data bus and raises a stall request to ctrl while the access is in flight. It presents rd/CSR writeback, pc, ins and an updated exception vector combinationally to the MEM/WB register.

## Interface
- `ACK_TIMEOUT`, 255: bus watchdog limit in cycles, 1..255; only used with `LSU_TIMEOUT_EN`.
- `ck_i` in 1: clock, rising edge.
- `rs_n_i` in 1: reset, asynchronous, active-low.
- `stall_i` in 6: ctrl stall vector; bit 4 is MEM/WB.
- `flush_i` in 1: pipeline flush.
- `uop_i`, `rd_we_i`, `rd_a_i`, `rd_wd_i`, `csr_we_i`, `csr_wa_i`, `csr_wd_i`, `exception_i`, `pc_i`, `ins_i`, `mem_a_i`, `mem_wd_i` in (`AluOpBus`/1/`REG_BUS_A`/`REG_BUS_D`): EX/MEM register outputs.
- `dbus_req_o` out 1: access request. `dbus_we_o` out 1: store. `dbus_a_o` out 32: word-aligned address. `dbus_wd_o` out 32: lane-steered store data. `dbus_be_o` out 4: byte enables.
- `dbus_rd_i` in 32: read data. `dbus_ack_i` in 1: completion. `dbus_err_i` in 1: bus error, qualified by ack.
- `stall_req_o` out 1: stall request to ctrl.
- `rd_we_o`, `rd_a_o`, `rd_wd_o`, `csr_we_o`, `csr_wa_o`, `csr_wd_o`, `exception_o`, `pc_o`, `ins_o` out: to MEM/WB.

## Operation
- Memory uops are `UOP_LB`, `UOP_LH`, `UOP_LW`, `UOP_LBU`, `UOP_LHU`, `UOP_SB`, `UOP_SH` and `UOP_SW`. All other uops pass through with no bus activity and no stall.
- Misaligned access: H/HU/SH with a[0]=1, or W with a[1:0]≠0.
  - Sets `EXC_LOAD_MISALIGN` (bit 4) or `EXC_STORE_MISALIGN` (bit 6) in `exception_o`.
  - No bus request, no stall.
- If `exception_i`≠0, no bus access is made and the exception passes through.
- Whenever `exception_o`≠0, `rd_we_o` and `csr_we_o` are forced to 0.
- FSM, state register reset to IDLE:
  - IDLE: a valid aligned memory op asserts `stall_req_o` combinationally and loads the dbus registers. Next state is BUSY.
  - BUSY: req held, stall held. On ack, next state is DONE. On ack with `dbus_err_i`, next state is DONE and `EXC_LOAD_FAULT` (bit 5) or `EXC_STORE_FAULT` (bit 7) is latched.
  - DONE: req=0, stall=0. Loads drive `rd_wd_o` from the latched, extended data. Next state is IDLE when `stall_i[4]`==`NO_STOP`, otherwise the block stays in DONE.
  - DRAIN: entered from BUSY on `flush_i`. Req and stall are held until ack. Data and errors are discarded. Next state is IDLE.
- `flush_i` in IDLE or DONE: next state is IDLE.
- Store lanes:
  - SB: byte replicated ×4, be=1<<a[1:0].
  - SH: half replicated ×2, be=4'b0011<<a[1:0].
  - SW: be=4'hF.
- Load: byte/half selected by a[1:0]. LB/LH sign-extend; LBU/LHU zero-extend.
- An ack outside BUSY/DRAIN is ignored.

## Timing
- Reset, asynchronous: state IDLE. `dbus_req_o`, `dbus_we_o`, `dbus_a_o`, `dbus_wd_o`, `dbus_be_o` and the load-data/fault registers all go to 0 immediately, including mid-transaction.
- Pass-through outputs follow inputs combinationally.
- Bus rules:
  - req, we, a, wd and be stay stable from the edge that raises req until the edge that samples ack=1.
  - req falls at the following edge.
- Zero-wait ack gives: cycle 0 IDLE with stall=1; cycle 1 BUSY with req=1 and ack sampled; cycle 2 DONE with result valid and stall=0. That is a minimum of 2 stall cycles.
- Each extra ack wait state adds one stall cycle.

## Configuration
- `LSU_TIMEOUT_EN` defined:
  - An 8-bit counter clears on entry to BUSY/DRAIN and increments each waiting cycle.
  - When it reaches `ACK_TIMEOUT`, req drops, the fault bit is set (BUSY only) and the next state is DONE (BUSY) or IDLE (DRAIN).
- Undefined: the block waits for ack indefinitely, and the counter logic is absent.

## Structure
- `defines.v` gains the `UOP_L*`/`UOP_S*` codes and the `EXC_*` bit indices (mcause numbering).
- FSM state encodings are local parameters.
- One combinational sub-module, `lsu_align`, handles store lane steering, byte enables, load extract/extend and the misalign check.

## Test plan
- LW a=0x100, ack in first BUSY cycle, rd=0xDEADBEEF → `rd_wd_o`=0xDEADBEEF in cycle 2; `stall_req_o` high for 2 cycles.
- LB a=0x103, rd=0x80xxxxxx → `rd_wd_o`=0xFFFFFF80. LBU at the same address → 0x00000080.
- SH a=0x102, wd=0x1234ABCD → `dbus_wd_o`=0xABCDABCD, be=4'b1100, we=1.
- LW a=0x101 → no req, `exception_o` bit 4=1, `rd_we_o`=0, no stall.
- SW with ack delayed 5 cycles, `flush_i` on BUSY cycle 2 → DRAIN, req held until ack, no writeback, then IDLE.
- With `LSU_TIMEOUT_EN` and `ACK_TIMEOUT`=4, LW never acked → req drops after 4 cycles, bit 5 set. Async reset mid-BUSY → req=0 immediately.

Source files
------------

// File: rtl/lsu_pkg.sv
// Shared widths, uop codes, exception bit indices (mcause numbering) and decode helpers for the lsu.
package lsu_pkg;
  localparam int UOP_W       = 8;
  localparam int REG_A_W     = 5;
  localparam int REG_D_W     = 32;
  localparam int CSR_A_W     = 12;
  localparam int EXC_W       = 32;
  localparam int STALL_W     = 6;
  localparam int STALL_MEMWB = 4;

  localparam logic NO_STOP = 1'b0;

  localparam logic [UOP_W-1:0] UOP_NOP = 8'h00;
  localparam logic [UOP_W-1:0] UOP_LB  = 8'h20;
  localparam logic [UOP_W-1:0] UOP_LH  = 8'h21;
  localparam logic [UOP_W-1:0] UOP_LW  = 8'h22;
  localparam logic [UOP_W-1:0] UOP_LBU = 8'h23;
  localparam logic [UOP_W-1:0] UOP_LHU = 8'h24;
  localparam logic [UOP_W-1:0] UOP_SB  = 8'h28;
  localparam logic [UOP_W-1:0] UOP_SH  = 8'h29;
  localparam logic [UOP_W-1:0] UOP_SW  = 8'h2A;

  localparam int EXC_LOAD_MISALIGN  = 4;
  localparam int EXC_LOAD_FAULT     = 5;
  localparam int EXC_STORE_MISALIGN = 6;
  localparam int EXC_STORE_FAULT    = 7;

  typedef struct packed {
    logic        req;
    logic        we;
    logic [31:0] a;
    logic [31:0] wd;
    logic [3:0]  be;
  } dbus_req_t;

  function automatic logic uop_is_load(input logic [UOP_W-1:0] u);
    return (u == UOP_LB) || (u == UOP_LH) || (u == UOP_LW) || (u == UOP_LBU) || (u == UOP_LHU);
  endfunction

  function automatic logic uop_is_store(input logic [UOP_W-1:0] u);
    return (u == UOP_SB) || (u == UOP_SH) || (u == UOP_SW);
  endfunction
endpackage

// File: rtl/lsu_align.sv
// Combinational lane logic: store steering, byte enables, load extract/extend and misalign check.
module lsu_align
  import lsu_pkg::*;
(
  input  logic [UOP_W-1:0] uop_i,
  input  logic [1:0]       a_i,
  input  logic [31:0]      st_d_i,
  input  logic [31:0]      rd_i,
  output logic [31:0]      st_wd_o,
  output logic [3:0]       be_o,
  output logic [31:0]      ld_d_o,
  output logic             misalign_o
);
  logic [31:0] sh;

  always_comb begin
    st_wd_o    = st_d_i;
    be_o       = 4'hF;
    misalign_o = 1'b0;
    ld_d_o     = rd_i;
    // bring the addressed byte/half down to bit 0 before extending
    sh         = rd_i >> {a_i, 3'b000};
    case (uop_i)
      UOP_SB: begin
        st_wd_o = {4{st_d_i[7:0]}};
        be_o    = 4'b0001 << a_i;
      end
      UOP_SH: begin
        st_wd_o    = {2{st_d_i[15:0]}};
        be_o       = 4'b0011 << a_i;
        misalign_o = a_i[0];
      end
      UOP_SW: misalign_o = |a_i;
      UOP_LB: begin
        be_o   = 4'b0001 << a_i;
        ld_d_o = {{24{sh[7]}}, sh[7:0]};
      end
      UOP_LBU: begin
        be_o   = 4'b0001 << a_i;
        ld_d_o = {24'h0, sh[7:0]};
      end
      UOP_LH: begin
        be_o       = 4'b0011 << a_i;
        ld_d_o     = {{16{sh[15]}}, sh[15:0]};
        misalign_o = a_i[0];
      end
      UOP_LHU: begin
        be_o       = 4'b0011 << a_i;
        ld_d_o     = {16'h0, sh[15:0]};
        misalign_o = a_i[0];
      end
      UOP_LW: misalign_o = |a_i;
      default: ;
    endcase
  end
endmodule

// File: rtl/lsu.sv
// MEM-stage load/store unit: registered req/ack data-bus access with stall to ctrl.
// Optional ack watchdog enabled by defining LSU_TIMEOUT_EN.
module lsu
  import lsu_pkg::*;
#(
  parameter int ACK_TIMEOUT = 255
) (
  input  logic               ck_i,
  input  logic               rs_n_i,
  input  logic [STALL_W-1:0] stall_i,
  input  logic               flush_i,
  input  logic [UOP_W-1:0]   uop_i,
  input  logic               rd_we_i,
  input  logic [REG_A_W-1:0] rd_a_i,
  input  logic [REG_D_W-1:0] rd_wd_i,
  input  logic               csr_we_i,
  input  logic [CSR_A_W-1:0] csr_wa_i,
  input  logic [REG_D_W-1:0] csr_wd_i,
  input  logic [EXC_W-1:0]   exception_i,
  input  logic [31:0]        pc_i,
  input  logic [31:0]        ins_i,
  input  logic [31:0]        mem_a_i,
  input  logic [31:0]        mem_wd_i,
  output logic               dbus_req_o,
  output logic               dbus_we_o,
  output logic [31:0]        dbus_a_o,
  output logic [31:0]        dbus_wd_o,
  output logic [3:0]         dbus_be_o,
  input  logic [31:0]        dbus_rd_i,
  input  logic               dbus_ack_i,
  input  logic               dbus_err_i,
  output logic               stall_req_o,
  output logic               rd_we_o,
  output logic [REG_A_W-1:0] rd_a_o,
  output logic [REG_D_W-1:0] rd_wd_o,
  output logic               csr_we_o,
  output logic [CSR_A_W-1:0] csr_wa_o,
  output logic [REG_D_W-1:0] csr_wd_o,
  output logic [EXC_W-1:0]   exception_o,
  output logic [31:0]        pc_o,
  output logic [31:0]        ins_o
);
  localparam logic [1:0] ST_IDLE  = 2'd0;
  localparam logic [1:0] ST_BUSY  = 2'd1;
  localparam logic [1:0] ST_DONE  = 2'd2;
  localparam logic [1:0] ST_DRAIN = 2'd3;

  logic [1:0]  state_q, state_d;
  dbus_req_t   bus_q, bus_d;
  logic [31:0] ld_q, ld_d;
  logic        fault_q, fault_d;
  logic        is_ld, is_st, misalign, start, tmo;
  logic        bus_ld, bus_drop, rsp_ld;
  logic [31:0] st_wd, ld_ext;
  logic [3:0]  be;
  logic [EXC_W-1:0] exc;
  logic        unused_stall;

  assign unused_stall = ^{stall_i[STALL_W-1:STALL_MEMWB+1], stall_i[STALL_MEMWB-1:0]};

  lsu_align u_align (
    .uop_i      (uop_i),
    .a_i        (mem_a_i[1:0]),
    .st_d_i     (mem_wd_i),
    .rd_i       (dbus_rd_i),
    .st_wd_o    (st_wd),
    .be_o       (be),
    .ld_d_o     (ld_ext),
    .misalign_o (misalign)
  );

  assign is_ld = uop_is_load(uop_i);
  assign is_st = uop_is_store(uop_i);
  assign start = (is_ld | is_st) & ~misalign & (exception_i == '0) & ~flush_i;

`ifdef LSU_TIMEOUT_EN
  logic [7:0] cnt_q, cnt_d;

  assign tmo = (cnt_q + 8'd1) == 8'(ACK_TIMEOUT);

  // counts only while parked in BUSY/DRAIN; any state change restarts it
  always_comb begin
    cnt_d = '0;
    if ((state_q == ST_BUSY || state_q == ST_DRAIN) && state_d == state_q) cnt_d = cnt_q + 8'd1;
  end

  always_ff @(posedge ck_i or negedge rs_n_i)
    if (!rs_n_i) cnt_q <= '0;
    else         cnt_q <= cnt_d;
`else
  logic unused_tmo;
  assign unused_tmo = (ACK_TIMEOUT == 0);
  assign tmo        = 1'b0;
`endif

  always_ff @(posedge ck_i or negedge rs_n_i)
    if (!rs_n_i) state_q <= ST_IDLE;
    else         state_q <= state_d;

  always_comb begin
    state_d = state_q;
    case (state_q)
      ST_IDLE: if (start) state_d = ST_BUSY;
      ST_BUSY: begin
        // a flush racing the ack has nothing left to wait for
        if (flush_i)                 state_d = (dbus_ack_i | tmo) ? ST_IDLE : ST_DRAIN;
        else if (dbus_ack_i | tmo)   state_d = ST_DONE;
      end
      ST_DONE: if (flush_i || stall_i[STALL_MEMWB] == NO_STOP) state_d = ST_IDLE;
      ST_DRAIN: if (dbus_ack_i | tmo) state_d = ST_IDLE;
      default: state_d = ST_IDLE;
    endcase
  end

  always_comb begin
    stall_req_o = 1'b0;
    bus_ld      = 1'b0;
    bus_drop    = 1'b0;
    rsp_ld      = 1'b0;
    case (state_q)
      ST_IDLE: begin
        stall_req_o = start;
        bus_ld      = start;
      end
      ST_BUSY: begin
        stall_req_o = 1'b1;
        bus_drop    = dbus_ack_i | tmo;
        rsp_ld      = (dbus_ack_i | tmo) & ~flush_i;
      end
      ST_DRAIN: begin
        stall_req_o = 1'b1;
        bus_drop    = dbus_ack_i | tmo;
      end
      default: ;
    endcase
  end

  always_comb begin
    bus_d = bus_q;
    if (bus_ld) begin
      bus_d.req = 1'b1;
      bus_d.we  = is_st;
      bus_d.a   = {mem_a_i[31:2], 2'b00};
      bus_d.wd  = is_st ? st_wd : '0;
      bus_d.be  = be;
    end else if (bus_drop) begin
      bus_d.req = 1'b0;
    end
  end

  always_comb begin
    ld_d    = ld_q;
    fault_d = fault_q;
    if (rsp_ld) begin
      ld_d    = ld_ext;
      fault_d = dbus_ack_i ? dbus_err_i : 1'b1;
    end
  end

  always_ff @(posedge ck_i or negedge rs_n_i)
    if (!rs_n_i) begin
      bus_q   <= '0;
      ld_q    <= '0;
      fault_q <= 1'b0;
    end else begin
      bus_q   <= bus_d;
      ld_q    <= ld_d;
      fault_q <= fault_d;
    end

  assign dbus_req_o = bus_q.req;
  assign dbus_we_o  = bus_q.we;
  assign dbus_a_o   = bus_q.a;
  assign dbus_wd_o  = bus_q.wd;
  assign dbus_be_o  = bus_q.be;

  // misalign/fault only decorate a memory op that arrived clean
  always_comb begin
    exc = exception_i;
    if ((is_ld | is_st) && exception_i == '0) begin
      if (misalign) exc[is_st ? EXC_STORE_MISALIGN : EXC_LOAD_MISALIGN] = 1'b1;
      if (state_q == ST_DONE && fault_q) exc[is_st ? EXC_STORE_FAULT : EXC_LOAD_FAULT] = 1'b1;
    end
  end

  assign exception_o = exc;
  assign rd_we_o     = rd_we_i & (exc == '0);
  assign csr_we_o    = csr_we_i & (exc == '0);
  assign rd_a_o      = rd_a_i;
  assign rd_wd_o     = (state_q == ST_DONE && is_ld) ? ld_q : rd_wd_i;
  assign csr_wa_o    = csr_wa_i;
  assign csr_wd_o    = csr_wd_i;
  assign pc_o        = pc_i;
  assign ins_o       = ins_i;
endmodule

// File: tb/tb_lsu.sv
// Randomized bench for lsu against a behavioural byte-lane/transaction model.
module tb_lsu;
  import lsu_pkg::*;

`ifdef LSU_TIMEOUT_EN
  localparam int TMO = 4;
`else
  localparam int TMO = 255;
`endif

  logic               ck_i, rs_n_i;
  logic [STALL_W-1:0] stall_i;
  logic               flush_i;
  logic [UOP_W-1:0]   uop_i;
  logic               rd_we_i, csr_we_i;
  logic [REG_A_W-1:0] rd_a_i;
  logic [REG_D_W-1:0] rd_wd_i, csr_wd_i;
  logic [CSR_A_W-1:0] csr_wa_i;
  logic [EXC_W-1:0]   exception_i;
  logic [31:0]        pc_i, ins_i, mem_a_i, mem_wd_i;
  logic               dbus_req_o, dbus_we_o;
  logic [31:0]        dbus_a_o, dbus_wd_o;
  logic [3:0]         dbus_be_o;
  logic [31:0]        dbus_rd_i;
  logic               dbus_ack_i, dbus_err_i, stall_req_o;
  logic               rd_we_o, csr_we_o;
  logic [REG_A_W-1:0] rd_a_o;
  logic [REG_D_W-1:0] rd_wd_o, csr_wd_o;
  logic [CSR_A_W-1:0] csr_wa_o;
  logic [EXC_W-1:0]   exception_o;
  logic [31:0]        pc_o, ins_o;

  lsu #(.ACK_TIMEOUT(TMO)) dut (
    .ck_i(ck_i), .rs_n_i(rs_n_i), .stall_i(stall_i), .flush_i(flush_i), .uop_i(uop_i),
    .rd_we_i(rd_we_i), .rd_a_i(rd_a_i), .rd_wd_i(rd_wd_i), .csr_we_i(csr_we_i),
    .csr_wa_i(csr_wa_i), .csr_wd_i(csr_wd_i), .exception_i(exception_i), .pc_i(pc_i),
    .ins_i(ins_i), .mem_a_i(mem_a_i), .mem_wd_i(mem_wd_i), .dbus_req_o(dbus_req_o),
    .dbus_we_o(dbus_we_o), .dbus_a_o(dbus_a_o), .dbus_wd_o(dbus_wd_o), .dbus_be_o(dbus_be_o),
    .dbus_rd_i(dbus_rd_i), .dbus_ack_i(dbus_ack_i), .dbus_err_i(dbus_err_i),
    .stall_req_o(stall_req_o), .rd_we_o(rd_we_o), .rd_a_o(rd_a_o), .rd_wd_o(rd_wd_o),
    .csr_we_o(csr_we_o), .csr_wa_o(csr_wa_o), .csr_wd_o(csr_wd_o), .exception_o(exception_o),
    .pc_o(pc_o), .ins_o(ins_o)
  );

  initial ck_i = 1'b0;
  always #5 ck_i = ~ck_i;

  int n_chk = 0;
  int n_err = 0;

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_chk++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s: got %h want %h", tag, got, exp);
    end
  endtask

  // byte-lane model: sizes, offsets and extension from plain arithmetic
  function automatic void model(input logic [7:0] u, input logic [31:0] a, input logic [31:0] wd,
                                input logic [31:0] rdat, output bit ld, output bit st,
                                output bit mis, output logic [31:0] ewd, output logic [3:0] ebe,
                                output logic [31:0] eld);
    int size, off;
    bit sgn;
    logic [31:0] mask, v;
    ld = 0; st = 0; sgn = 0; size = 4;
    case (u)
      UOP_LB:  begin ld = 1; size = 1; sgn = 1; end
      UOP_LH:  begin ld = 1; size = 2; sgn = 1; end
      UOP_LW:  ld = 1;
      UOP_LBU: begin ld = 1; size = 1; end
      UOP_LHU: begin ld = 1; size = 2; end
      UOP_SB:  begin st = 1; size = 1; end
      UOP_SH:  begin st = 1; size = 2; end
      UOP_SW:  st = 1;
      default: ;
    endcase
    off  = int'(a % 32'd4);
    mis  = (ld || st) && (off % size != 0);
    mask = (size == 4) ? 32'hFFFF_FFFF : (32'd1 << (8 * size)) - 32'd1;
    ebe  = 4'(((1 << size) - 1) << off);
    ewd  = (wd & mask) * ((size == 1) ? 32'h0101_0101 : (size == 2) ? 32'h0001_0001 : 32'd1);
    v    = (rdat >> (8 * off)) & mask;
    if (sgn && v[8*size-1]) v = v | ~mask;
    eld  = v;
  endfunction

  task automatic set_in(input logic [7:0] u, input logic [31:0] a, input logic [31:0] wd,
                        input logic [31:0] exc);
    uop_i = u; mem_a_i = a; mem_wd_i = wd; exception_i = exc;
    rd_we_i = 1'($urandom); rd_a_i = 5'($urandom); rd_wd_i = $urandom;
    csr_we_i = 1'($urandom); csr_wa_i = 12'($urandom); csr_wd_i = $urandom;
    pc_i = $urandom; ins_i = $urandom;
  endtask

  task automatic chk_wb(input string tag, input logic [31:0] exc, input logic [31:0] wd);
    chk({tag, "_exc"}, exception_o, exc);
    chk({tag, "_rdwe"}, 32'(rd_we_o), 32'(rd_we_i && exc == 32'd0));
    chk({tag, "_csrwe"}, 32'(csr_we_o), 32'(csr_we_i && exc == 32'd0));
    chk({tag, "_rdwd"}, rd_wd_o, wd);
    chk({tag, "_pc"}, pc_o, pc_i);
  endtask

  // one instruction through MEM: waits = ack wait states, hold = extra MEM/WB stall cycles
  task automatic run_op(input logic [7:0] u, input logic [31:0] a, input logic [31:0] wd,
                        input logic [31:0] rdat, input logic [31:0] exc_in, input int waits,
                        input bit err, input int hold);
    bit ld, st, mis;
    logic [31:0] ewd, eld, eexc;
    logic [3:0] ebe;
    int stalls;
    stalls = 0;
    model(u, a, wd, rdat, ld, st, mis, ewd, ebe, eld);
    @(negedge ck_i);
    set_in(u, a, wd, exc_in);
    flush_i = 0; stall_i = '0; dbus_ack_i = 0; dbus_err_i = 0;
    #1;
    if (exc_in != 0 || !(ld || st) || mis) begin
      eexc = exc_in;
      if (exc_in == 0 && mis) eexc[ld ? 4 : 6] = 1'b1;
      chk("pt_stall", 32'(stall_req_o), 32'd0);
      chk("pt_req", 32'(dbus_req_o), 32'd0);
      chk_wb("pt", eexc, rd_wd_i);
    end else begin
      chk("c0_stall", 32'(stall_req_o), 32'd1);
      chk("c0_req", 32'(dbus_req_o), 32'd0);
      if (stall_req_o) stalls++;
      for (int w = 0; w <= waits; w++) begin
        @(negedge ck_i);
        dbus_ack_i = (w == waits);
        dbus_err_i = (w == waits) ? err : 1'($urandom_range(0, 1));
        dbus_rd_i  = (w == waits) ? rdat : $urandom;
        #1;
        if (stall_req_o) stalls++;
        chk("bus_req", 32'(dbus_req_o), 32'd1);
        chk("bus_we", 32'(dbus_we_o), 32'(st));
        chk("bus_a", dbus_a_o, a & ~32'h3);
        if (st) begin
          chk("bus_wd", dbus_wd_o, ewd);
          chk("bus_be", 32'(dbus_be_o), 32'(ebe));
        end
      end
      eexc = err ? (32'd1 << (ld ? 5 : 7)) : 32'd0;
      for (int h = 0; h <= hold; h++) begin
        @(negedge ck_i);
        dbus_ack_i = (h < hold);
        dbus_err_i = 0;
        dbus_rd_i  = $urandom;
        stall_i    = (h < hold) ? 6'b010000 : 6'b000000;
        #1;
        if (stall_req_o) stalls++;
        chk("done_req", 32'(dbus_req_o), 32'd0);
        chk_wb("done", eexc, ld ? eld : rd_wd_i);
      end
      chk("stall_cyc", stalls, waits + 2);
    end
    dbus_ack_i = 0; stall_i = '0;
  endtask

  logic [7:0] uops [9];

  initial begin
    uops = '{UOP_LB, UOP_LH, UOP_LW, UOP_LBU, UOP_LHU, UOP_SB, UOP_SH, UOP_SW, 8'h01};
    rs_n_i = 0; flush_i = 0; stall_i = '0; dbus_ack_i = 0; dbus_err_i = 0; dbus_rd_i = '0;
    set_in(UOP_NOP, 32'h0, 32'h0, 32'h0);
    @(negedge ck_i); #1;
    chk("rst_req", 32'(dbus_req_o), 32'd0);
    chk("rst_we", 32'(dbus_we_o), 32'd0);
    chk("rst_a", dbus_a_o, 32'd0);
    chk("rst_wd", dbus_wd_o, 32'd0);
    chk("rst_be", 32'(dbus_be_o), 32'd0);
    chk("rst_stall", 32'(stall_req_o), 32'd0);
    rs_n_i = 1;

    run_op(UOP_LW,  32'h100, 32'h0, 32'hDEADBEEF, 32'h0, 0, 0, 0);
    run_op(UOP_LB,  32'h103, 32'h0, 32'h80123456, 32'h0, 1, 0, 1);
    run_op(UOP_LBU, 32'h103, 32'h0, 32'h80123456, 32'h0, 0, 0, 0);
    run_op(UOP_SH,  32'h102, 32'h1234ABCD, 32'h0, 32'h0, 2, 0, 0);
    run_op(UOP_LW,  32'h101, 32'h0, 32'h0, 32'h0, 0, 0, 0);
    run_op(UOP_LH,  32'h102, 32'h0, 32'h7FFF0000, 32'h0, 0, 1, 2);

    // flush during BUSY sends the access to DRAIN until the late ack
    @(negedge ck_i);
    set_in(UOP_SW, 32'h200, 32'hCAFEF00D, 32'h0);
    #1; chk("fl_c0_stall", 32'(stall_req_o), 32'd1);
    @(negedge ck_i); #1; chk("fl_b1_req", 32'(dbus_req_o), 32'd1);
    @(negedge ck_i); flush_i = 1; #1; chk("fl_b2_req", 32'(dbus_req_o), 32'd1);
    @(negedge ck_i); flush_i = 0;
    set_in(UOP_NOP, 32'h0, 32'h0, 32'h0);
    for (int c = 0; c < 4; c++) begin
      if (c > 0) @(negedge ck_i);
      dbus_ack_i = (c == 3); dbus_err_i = (c == 3);
      #1;
      chk("fl_drain_req", 32'(dbus_req_o), 32'd1);
      chk("fl_drain_stall", 32'(stall_req_o), 32'd1);
      chk("fl_drain_wd", dbus_wd_o, 32'hCAFEF00D);
    end
    @(negedge ck_i); dbus_ack_i = 0; dbus_err_i = 0; #1;
    chk("fl_idle_req", 32'(dbus_req_o), 32'd0);
    chk("fl_idle_stall", 32'(stall_req_o), 32'd0);
    chk_wb("fl_idle", 32'h0, rd_wd_i);
    run_op(UOP_LW, 32'h204, 32'h0, 32'h13572468, 32'h0, 0, 0, 0);

`ifdef LSU_TIMEOUT_EN
    @(negedge ck_i);
    set_in(UOP_LW, 32'h400, 32'h0, 32'h0);
    #1; chk("to_c0_stall", 32'(stall_req_o), 32'd1);
    for (int c = 0; c < TMO; c++) begin
      @(negedge ck_i); #1;
      chk("to_req", 32'(dbus_req_o), 32'd1);
    end
    @(negedge ck_i); #1;
    chk("to_req_drop", 32'(dbus_req_o), 32'd0);
    chk("to_stall", 32'(stall_req_o), 32'd0);
    chk("to_exc", exception_o, 32'h20);
    chk("to_rdwe", 32'(rd_we_o), 32'd0);
`endif

    for (int n = 0; n < 200; n++) begin
      run_op(uops[$urandom_range(0, 8)], $urandom, $urandom, $urandom,
             ($urandom_range(0, 15) == 0) ? 32'h4 : 32'h0, $urandom_range(0, 3),
             ($urandom_range(0, 7) == 0), $urandom_range(0, 2));
    end

    // asynchronous reset in the middle of a bus access
    @(negedge ck_i);
    set_in(UOP_LW, 32'h300, 32'h0, 32'h0);
    @(negedge ck_i); #1;
    chk("ar_busy_req", 32'(dbus_req_o), 32'd1);
    #1 rs_n_i = 0;
    #1;
    chk("ar_req", 32'(dbus_req_o), 32'd0);
    chk("ar_a", dbus_a_o, 32'd0);
    chk("ar_be", 32'(dbus_be_o), 32'd0);
    @(negedge ck_i);
    set_in(UOP_NOP, 32'h0, 32'h0, 32'h0);
    rs_n_i = 1;
    run_op(UOP_SB, 32'h301, 32'h000000A5, 32'h0, 32'h0, 1, 0, 0);

    $display("Result: errors=%0d of %0d checks", n_err, n_chk);
    $finish;
  end
endmodule
